// File: rtl/seg7_pkg.sv
// rtl/seg7_pkg.sv - shared types and constants for the 7-segment scan controller
package seg7_pkg;

   typedef enum logic {BLANK, SHOW} state_t;

   localparam logic [6:0] SEG_OFF = 7'h7F;

   // Active-low {g,f,e,d,c,b,a} patterns for 0-F
   localparam logic [6:0] HEX_SEG [16] = '{
      7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
      7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
   };

endpackage

// File: rtl/seg7_scan_controller_if.sv
// rtl/seg7_scan_controller_if.sv - display value inputs and board pin outputs of the scan controller
interface seg7_scan_controller_if #(parameter int N_DIGITS = 8);

   logic                  scan_en;
   logic [4*N_DIGITS-1:0] digits;
   logic [N_DIGITS-1:0]   dp_in;
   logic [N_DIGITS-1:0]   digit_mask;
   logic [N_DIGITS-1:0]   anodes;
   logic [6:0]            segments;
   logic                  dp;
   logic                  frame_done;

   modport master (
      output scan_en, digits, dp_in, digit_mask,
      input  anodes, segments, dp, frame_done
   );

   modport slave (
      input  scan_en, digits, dp_in, digit_mask,
      output anodes, segments, dp, frame_done
   );

endinterface

// File: rtl/hex_to_sevenseg.sv
// rtl/hex_to_sevenseg.sv - combinational hex digit to active-low segment decoder
module hex_to_sevenseg
   import seg7_pkg::*;
(
   input  logic [3:0] value,
   output logic [6:0] segments
);

   assign segments = HEX_SEG[value];

endmodule

// File: rtl/seg7_scan_controller.sv
// rtl/seg7_scan_controller.sv - round-robin multiplexed 7-segment scanner with blanking gaps
module seg7_scan_controller
   import seg7_pkg::*;
#(
   parameter int N_DIGITS     = 8,
   parameter int SHOW_CYCLES  = 100000,
   parameter int BLANK_CYCLES = 1000
) (
   input  logic clk,
   input  logic resetN,
   seg7_scan_controller_if.slave bus
);

   localparam int MAX_CYCLES = (SHOW_CYCLES > BLANK_CYCLES) ? SHOW_CYCLES : BLANK_CYCLES;
   localparam int CW = $clog2(MAX_CYCLES + 1);
   localparam int IW = $clog2(N_DIGITS);
   localparam logic [CW-1:0] SHOW_LOAD  = CW'(SHOW_CYCLES - 1);
   localparam logic [CW-1:0] BLANK_LOAD = CW'(BLANK_CYCLES - 1);
   localparam logic [IW-1:0] LAST_IDX   = IW'(N_DIGITS - 1);

   state_t                state;
   logic [CW-1:0]         cnt;
   logic [IW-1:0]         idx;
   logic [4*N_DIGITS-1:0] snap_digits;
   logic [N_DIGITS-1:0]   snap_dp;
   logic [N_DIGITS-1:0]   snap_mask;
   logic [N_DIGITS-1:0]   anodes_q;
   logic [6:0]            segments_q;
   logic                  dp_q;
   logic                  frame_done_q;

   // Digit 0 is shown from the live inputs on the same edge they are latched
   logic                  take_snap;
   logic [4*N_DIGITS-1:0] cur_digits;
   logic [N_DIGITS-1:0]   cur_dp;
   logic [N_DIGITS-1:0]   cur_mask;
   logic [3:0]            sel_digit;
   logic [6:0]            sel_seg;
   logic [N_DIGITS-1:0]   sel_anodes;

   assign take_snap  = (state == BLANK) && (cnt == '0) && (idx == '0);
   assign cur_digits = take_snap ? bus.digits     : snap_digits;
   assign cur_dp     = take_snap ? bus.dp_in      : snap_dp;
   assign cur_mask   = take_snap ? bus.digit_mask : snap_mask;
   assign sel_digit  = cur_digits[4*idx +: 4];
   assign sel_anodes = cur_mask[idx] ? ~(N_DIGITS'(1) << idx) : '1;

   hex_to_sevenseg u_dec (
      .value    (sel_digit),
      .segments (sel_seg)
   );

   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         state        <= BLANK;
         cnt          <= BLANK_LOAD;
         idx          <= '0;
         snap_digits  <= '0;
         snap_dp      <= '0;
         snap_mask    <= '0;
         anodes_q     <= '1;
         segments_q   <= SEG_OFF;
         dp_q         <= 1'b1;
         frame_done_q <= 1'b0;
      end else begin
         // Frame end still reports even when scanning is being stopped on this edge
         frame_done_q <= (state == SHOW) && (cnt == '0) && (idx == LAST_IDX);
         if (!bus.scan_en) begin
            state      <= BLANK;
            cnt        <= BLANK_LOAD;
            idx        <= '0;
            anodes_q   <= '1;
            segments_q <= SEG_OFF;
            dp_q       <= 1'b1;
         end else if (cnt != '0) begin
            cnt <= cnt - 1'b1;
         end else if (state == BLANK) begin
            state <= SHOW;
            cnt   <= SHOW_LOAD;
            if (take_snap) begin
               snap_digits <= bus.digits;
               snap_dp     <= bus.dp_in;
               snap_mask   <= bus.digit_mask;
            end
            anodes_q   <= sel_anodes;
            segments_q <= sel_seg;
            dp_q       <= ~cur_dp[idx];
         end else begin
            state      <= BLANK;
            cnt        <= BLANK_LOAD;
            idx        <= (idx == LAST_IDX) ? '0 : idx + 1'b1;
            anodes_q   <= '1;
            segments_q <= SEG_OFF;
            dp_q       <= 1'b1;
         end
      end
   end

   assign bus.anodes     = anodes_q;
   assign bus.segments   = segments_q;
   assign bus.dp         = dp_q;
   assign bus.frame_done = frame_done_q;

endmodule

// File: tb/tb_seg7_scan_controller.sv
// tb/tb_seg7_scan_controller.sv - directed self-checking bench for seg7_scan_controller
module tb_seg7_scan_controller;

   localparam logic [6:0] S1 = 7'h79;
   localparam logic [6:0] S2 = 7'h24;
   localparam logic [6:0] S3 = 7'h30;
   localparam logic [6:0] S4 = 7'h19;
   localparam logic [6:0] SA = 7'h08;
   localparam logic [6:0] SB = 7'h03;
   localparam logic [6:0] SC = 7'h46;
   localparam logic [6:0] SD = 7'h21;

   logic clk = 1'b0;
   logic resetN = 1'b0;
   int   n_assert = 0;
   int   n_fail = 0;

   seg7_scan_controller_if #(.N_DIGITS(4)) bus ();

   seg7_scan_controller #(
      .N_DIGITS     (4),
      .SHOW_CYCLES  (4),
      .BLANK_CYCLES (2)
   ) dut (
      .clk    (clk),
      .resetN (resetN),
      .bus    (bus.slave)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic check_blank(input string tag, input logic fd);
      check({tag, "_an"}, 32'(bus.anodes), 32'h0000000F);
      check({tag, "_seg"}, 32'(bus.segments), 32'h0000007F);
      check({tag, "_dp"}, 32'(bus.dp), 32'h00000001);
      check({tag, "_fd"}, 32'(bus.frame_done), 32'(fd));
   endtask

   task automatic check_show(input string tag, input logic [3:0] an, input logic [6:0] seg, input logic d);
      check({tag, "_an"}, 32'(bus.anodes), 32'(an));
      check({tag, "_seg"}, 32'(bus.segments), 32'(seg));
      check({tag, "_dp"}, 32'(bus.dp), 32'(d));
      check({tag, "_fd"}, 32'(bus.frame_done), 32'h0);
   endtask

   // Called at the first blank sample of a slot; returns at the next slot's first blank sample
   task automatic slot(input string tag, input logic [3:0] an, input logic [6:0] seg,
                       input logic d, input logic fd, input bit upd);
      check_blank({tag, "_b0"}, fd);
      @(negedge clk);
      check_blank({tag, "_b1"}, 1'b0);
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         check_show({tag, "_s"}, an, seg, d);
         if (upd && i == 0) bus.digits = 16'hABCD;
      end
      @(negedge clk);
   endtask

   initial begin
      bus.scan_en    = 1'($urandom);
      bus.digits     = 16'($urandom);
      bus.dp_in      = 4'($urandom);
      bus.digit_mask = 4'($urandom);
      repeat (3) @(negedge clk);
      check_blank("reset", 1'b0);

      bus.digits     = 16'h1234;
      bus.digit_mask = 4'hF;
      bus.dp_in      = 4'h0;
      bus.scan_en    = 1'b1;
      resetN         = 1'b1;
      slot("f1d0", 4'b1110, S4, 1'b1, 1'b0, 1'b0);
      slot("f1d1", 4'b1101, S3, 1'b1, 1'b0, 1'b0);
      slot("f1d2", 4'b1011, S2, 1'b1, 1'b0, 1'b0);
      slot("f1d3", 4'b0111, S1, 1'b1, 1'b0, 1'b0);

      slot("f2d0", 4'b1110, S4, 1'b1, 1'b1, 1'b0);
      slot("f2d1", 4'b1101, S3, 1'b1, 1'b0, 1'b1);
      slot("f2d2", 4'b1011, S2, 1'b1, 1'b0, 1'b0);
      slot("f2d3", 4'b0111, S1, 1'b1, 1'b0, 1'b0);

      slot("f3d0", 4'b1110, SD, 1'b1, 1'b1, 1'b0);
      bus.digit_mask = 4'b1010;
      bus.dp_in      = 4'b0010;
      slot("f3d1", 4'b1101, SC, 1'b1, 1'b0, 1'b0);
      slot("f3d2", 4'b1011, SB, 1'b1, 1'b0, 1'b0);
      slot("f3d3", 4'b0111, SA, 1'b1, 1'b0, 1'b0);

      slot("f4d0", 4'b1111, SD, 1'b1, 1'b1, 1'b0);
      slot("f4d1", 4'b1101, SC, 1'b0, 1'b0, 1'b0);
      slot("f4d2", 4'b1111, SB, 1'b1, 1'b0, 1'b0);
      slot("f4d3", 4'b0111, SA, 1'b1, 1'b0, 1'b0);

      bus.digit_mask = 4'hF;
      bus.dp_in      = 4'h0;
      slot("f5d0", 4'b1110, SD, 1'b1, 1'b1, 1'b0);
      slot("f5d1", 4'b1101, SC, 1'b1, 1'b0, 1'b0);
      check_blank("f5d2_b0", 1'b0);
      @(negedge clk);
      @(negedge clk);
      check_show("f5d2_s", 4'b1011, SB, 1'b1);
      #2 resetN = 1'b0;
      #1 check_blank("async_rst", 1'b0);
      @(negedge clk);
      resetN = 1'b1;
      slot("r_d0", 4'b1110, SD, 1'b1, 1'b0, 1'b0);
      slot("r_d1", 4'b1101, SC, 1'b1, 1'b0, 1'b0);

      @(negedge clk);
      @(negedge clk);
      check_show("r_d2_s", 4'b1011, SB, 1'b1);
      bus.scan_en = 1'b0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check_blank("scan_off", 1'b0);
      end
      bus.scan_en = 1'b1;
      slot("en_d0", 4'b1110, SD, 1'b1, 1'b0, 1'b0);
      slot("en_d1", 4'b1101, SC, 1'b1, 1'b0, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
